tdc_spi_arbiter: RTL and testbench

TDC_SPI_ARBITER -- requirements
Module: tdc_spi_arbiter

---
 rtl/tdc_spi_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_tdc_spi_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_spi_arbiter.sv
// tdc_spi_arbiter
// Two-port arbiter for a shared TDC SPI command engine. A granted request is
// captured and presented downstream as one level strobe plus cmd/num/wdata
// fields until the engine reports done, a timeout expires, or the request
// type is illegal. A completion pulse then returns to the owning port. A fixed
// idle gap follows, after which the next request can be granted.
//
// Ports
//   i_clk_50m, i_rst_n        clock, synchronous active-low reset
//   i_req0/1                  request, held until the matching done
//   i_type0/1                 0 one-byte, 1 write, 2 read, 3 illegal
//   i_cmd0/1, i_num0/1        TDC opcode, bit count minus 1
//   i_wdata0/1                write data
//   o_done0/1                 one-cycle completion pulse to the owner
//   o_rdata                   read data, valid with done, held until next done
//   o_err                     one-cycle pulse with done on timeout/illegal type
//   o_busy                    transaction in progress (BUSY or GAP)
//   o_owner                   port of current or last grant
//   o_cmd_tdc_wr/rd/byte      downstream level strobes
//   o_tdc_cmd/num/wr_data     downstream fields
//   i_tdc_cmd_done            downstream completion pulse
//   i_tdc_rd_data             downstream read data
module tdc_spi_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 200000,
  parameter int unsigned GAP_CYC     = 4,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic        i_clk_50m,
  input  logic        i_rst_n,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic [1:0]  i_type0,
  input  logic [1:0]  i_type1,
  input  logic [7:0]  i_cmd0,
  input  logic [7:0]  i_cmd1,
  input  logic [5:0]  i_num0,
  input  logic [5:0]  i_num1,
  input  logic [31:0] i_wdata0,
  input  logic [31:0] i_wdata1,
  output logic        o_done0,
  output logic        o_done1,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic        o_busy,
  output logic        o_owner,
  output logic        o_cmd_tdc_wr,
  output logic        o_cmd_tdc_rd,
  output logic        o_cmd_tdc_byte,
  output logic [7:0]  o_tdc_cmd,
  output logic [5:0]  o_tdc_num,
  output logic [31:0] o_tdc_wr_data,
  input  logic        i_tdc_cmd_done,
  input  logic [31:0] i_tdc_rd_data
);

  localparam int unsigned TO_W  = ($clog2(TIMEOUT_CYC + 1) > 18) ? $clog2(TIMEOUT_CYC + 1) : 18;
  localparam int unsigned GAP_W = ($clog2(GAP_CYC + 1) > 1) ? $clog2(GAP_CYC + 1) : 1;
  localparam int unsigned STV_W = ($clog2(STARVE_MAX + 1) > 1) ? $clog2(STARVE_MAX + 1) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [1:0] TY_BYTE = 2'd0;
  localparam logic [1:0] TY_WR   = 2'd1;
  localparam logic [1:0] TY_RD   = 2'd2;
  localparam logic [1:0] TY_ILL  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [TO_W-1:0]  busy_cnt_q, busy_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic [1:0]       type_q, type_d;

  logic        owner_d;
  logic        done0_d, done1_d, err_d, busy_d;
  logic        wr_d, rd_d, byte_d;
  logic [7:0]  cmd_d;
  logic [5:0]  num_d;
  logic [31:0] wdata_d, rdata_d;

  logic        fin, fin_err;

  // Arbitration: port 0 wins unless port 1 has been passed over STARVE_MAX times
  logic        grant1;
  logic [1:0]  sel_type;
  logic [7:0]  sel_cmd;
  logic [5:0]  sel_num;
  logic [31:0] sel_wdata;

  assign grant1    = i_req1 && (!i_req0 || (starve_q == STV_W'(STARVE_MAX)));
  assign sel_type  = grant1 ? i_type1  : i_type0;
  assign sel_cmd   = grant1 ? i_cmd1   : i_cmd0;
  assign sel_num   = grant1 ? i_num1   : i_num0;
  assign sel_wdata = grant1 ? i_wdata1 : i_wdata0;

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    starve_d   = starve_q;
    type_d     = type_q;
    owner_d    = o_owner;
    cmd_d      = o_tdc_cmd;
    num_d      = o_tdc_num;
    wdata_d    = o_tdc_wr_data;
    wr_d       = o_cmd_tdc_wr;
    rd_d       = o_cmd_tdc_rd;
    byte_d     = o_cmd_tdc_byte;
    rdata_d    = o_rdata;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    err_d      = 1'b0;
    fin        = 1'b0;
    fin_err    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_req0 || i_req1) begin
          // Starvation count only grows while port 1 is actually waiting
          if (grant1 || !i_req1) begin
            starve_d = '0;
          end else if (starve_q != STV_W'(STARVE_MAX)) begin
            starve_d = starve_q + STV_W'(1);
          end
          owner_d    = grant1;
          type_d     = sel_type;
          cmd_d      = sel_cmd;
          num_d      = (sel_type == TY_BYTE) ? 6'd0 : sel_num;
          wdata_d    = (sel_type == TY_BYTE) ? 32'd0 : sel_wdata;
          wr_d       = (sel_type == TY_WR);
          rd_d       = (sel_type == TY_RD);
          byte_d     = (sel_type == TY_BYTE);
          busy_cnt_d = '0;
          state_d    = ST_BUSY;
        end
      end

      ST_BUSY: begin
        // Done outranks timeout; an illegal type ends after one BUSY cycle
        if (type_q == TY_ILL) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (i_tdc_cmd_done) begin
          fin = 1'b1;
        end else if (busy_cnt_q == TO_W'(TIMEOUT_CYC)) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          busy_cnt_d = busy_cnt_q + TO_W'(1);
        end

        if (fin) begin
          wr_d       = 1'b0;
          rd_d       = 1'b0;
          byte_d     = 1'b0;
          cmd_d      = '0;
          num_d      = '0;
          wdata_d    = '0;
          rdata_d    = (!fin_err && (type_q == TY_RD)) ? i_tdc_rd_data : 32'd0;
          done0_d    = !o_owner;
          done1_d    = o_owner;
          err_d      = fin_err;
          busy_cnt_d = '0;
          gap_cnt_d  = '0;
          state_d    = ST_GAP;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, counters, captured type and all outputs
  always_ff @(posedge i_clk_50m) begin
    if (!i_rst_n) begin
      state_q        <= ST_IDLE;
      busy_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      starve_q       <= '0;
      type_q         <= '0;
      o_owner        <= 1'b0;
      o_tdc_cmd      <= '0;
      o_tdc_num      <= '0;
      o_tdc_wr_data  <= '0;
      o_cmd_tdc_wr   <= 1'b0;
      o_cmd_tdc_rd   <= 1'b0;
      o_cmd_tdc_byte <= 1'b0;
      o_rdata        <= '0;
      o_done0        <= 1'b0;
      o_done1        <= 1'b0;
      o_err          <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      state_q        <= state_d;
      busy_cnt_q     <= busy_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      starve_q       <= starve_d;
      type_q         <= type_d;
      o_owner        <= owner_d;
      o_tdc_cmd      <= cmd_d;
      o_tdc_num      <= num_d;
      o_tdc_wr_data  <= wdata_d;
      o_cmd_tdc_wr   <= wr_d;
      o_cmd_tdc_rd   <= rd_d;
      o_cmd_tdc_byte <= byte_d;
      o_rdata        <= rdata_d;
      o_done0        <= done0_d;
      o_done1        <= done1_d;
      o_err          <= err_d;
      o_busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_tdc_spi_arbiter.sv
// Scoreboard bench for tdc_spi_arbiter: expected completions are queued at
// issue time and a monitor checks every done pulse against the queue head.
module tb_tdc_spi_arbiter;

  localparam int T_TO  = 100;
  localparam int T_GAP = 4;
  localparam int T_STV = 4;
  localparam longint CYC = 20;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic [1:0]  type0, type1;
  logic [7:0]  cmd0, cmd1;
  logic [5:0]  num0, num1;
  logic [31:0] wdata0, wdata1;
  logic        done0, done1, err, busy, owner;
  logic [31:0] rdata;
  logic        s_wr, s_rd, s_byte;
  logic [7:0]  t_cmd;
  logic [5:0]  t_num;
  logic [31:0] t_wdata;
  logic        tdc_done;
  logic [31:0] tdc_rd;

  int          resp_delay;
  int          resp_wait;
  logic [31:0] resp_data;
  logic        resp_fire;
  logic        spur;

  assign tdc_done = resp_fire | spur;
  assign tdc_rd   = resp_data;

  tdc_spi_arbiter #(
    .TIMEOUT_CYC(T_TO), .GAP_CYC(T_GAP), .STARVE_MAX(T_STV)
  ) dut (
    .i_clk_50m(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_req1(req1), .i_type0(type0), .i_type1(type1),
    .i_cmd0(cmd0), .i_cmd1(cmd1), .i_num0(num0), .i_num1(num1),
    .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_done0(done0), .o_done1(done1), .o_rdata(rdata), .o_err(err),
    .o_busy(busy), .o_owner(owner),
    .o_cmd_tdc_wr(s_wr), .o_cmd_tdc_rd(s_rd), .o_cmd_tdc_byte(s_byte),
    .o_tdc_cmd(t_cmd), .o_tdc_num(t_num), .o_tdc_wr_data(t_wdata),
    .i_tdc_cmd_done(tdc_done), .i_tdc_rd_data(tdc_rd)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    longint      t;     // expected negedge time of done, 0 = untimed
  } exp_t;

  exp_t sbq[$];
  exp_t me;

  int checks = 0, errors = 0;
  int mchecks = 0, merrors = 0;
  logic [31:0] last_rdata;

  // Downstream engine: answers resp_delay cycles after a strobe appears
  initial begin
    resp_wait = 0;
    resp_fire = 1'b0;
  end
  always @(negedge clk) begin
    if (!(s_wr || s_rd || s_byte)) begin
      resp_wait = 0;
      resp_fire = 1'b0;
    end else begin
      resp_fire = (resp_delay >= 0) && (resp_wait == resp_delay);
      resp_wait = resp_wait + 1;
    end
  end

  // Monitor: every done pulse must match the scoreboard head
  always @(negedge clk) begin
    if (done0 || done1) begin
      mchecks++;
      if (sbq.size() == 0) begin
        merrors++;
        $display("FAIL unexpected_done t=%0t done0=%0b done1=%0b required=no done", $time, done0, done1);
      end else begin
        me = sbq.pop_front();
        if ((done0 && done1) || (done1 != (me.port == 1)) || (rdata !== me.rdata) ||
            (err !== me.err) || ((me.t != 0) && ($time != me.t))) begin
          merrors++;
          $display("FAIL done_resp t=%0t actual done0=%0b done1=%0b rdata=%h err=%0b required port=%0d rdata=%h err=%0b t=%0d",
                   $time, done0, done1, rdata, err, me.port, me.rdata, me.err, me.t);
        end
      end
    end else if (err) begin
      mchecks++;
      merrors++;
      $display("FAIL err_without_done t=%0t actual err=1 required err=0", $time);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, 32'({done0, done1, err, busy, owner, s_wr, s_rd, s_byte, t_cmd, t_num}), 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_wdata"}, t_wdata, 32'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  // One single-port transaction, issued at a negedge with the DUT idle
  task automatic do_txn(input int port, input logic [1:0] ty, input logic [7:0] cmd,
                        input logic [5:0] num, input logic [31:0] wd, input int dly,
                        input logic [31:0] rdat, input bit early, input bit spur_gap);
    longint t0;
    int m, n, g;
    logic e_err, strobe_seen;
    logic [31:0] e_rd;
    exp_t ex;
    wait_idle();
    resp_delay = dly;
    resp_data  = rdat;
    if (port == 0) begin
      req0 = 1'b1; type0 = ty; cmd0 = cmd; num0 = num; wdata0 = wd;
    end else begin
      req1 = 1'b1; type1 = ty; cmd1 = cmd; num1 = num; wdata1 = wd;
    end
    t0 = $time;
    // Reference: illegal ends after one BUSY cycle; otherwise done is taken
    // while the BUSY count is <= TIMEOUT, else the block aborts at TIMEOUT.
    if (ty == 2'd3) begin
      m = 0; e_err = 1'b1;
    end else if (dly < 0 || dly > T_TO) begin
      m = T_TO; e_err = 1'b1;
    end else begin
      m = dly; e_err = 1'b0;
    end
    e_rd = (ty == 2'd2 && !e_err) ? rdat : 32'd0;
    ex.port = port; ex.rdata = e_rd; ex.err = e_err; ex.t = t0 + CYC * longint'(2 + m);
    sbq.push_back(ex);

    @(negedge clk);
    chk("strobe_wr", 32'(s_wr), 32'(ty == 2'd1));
    chk("strobe_rd", 32'(s_rd), 32'(ty == 2'd2));
    chk("strobe_byte", 32'(s_byte), 32'(ty == 2'd0));
    chk("owner", 32'(owner), 32'(port));
    chk("rdata_hold", rdata, last_rdata);
    if (ty != 2'd3) begin
      chk("tdc_cmd", 32'(t_cmd), 32'(cmd));
      chk("tdc_num", 32'(t_num), (ty == 2'd0) ? 32'd0 : 32'(num));
      chk("tdc_wdata", t_wdata, (ty == 2'd0) ? 32'd0 : wd);
    end
    if (early) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end

    n = 0;
    while (!(port == 0 ? done0 : done1) && n < T_TO + 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(port == 0 ? done0 : done1), 32'd1);
    req0 = 1'b0;
    req1 = 1'b0;
    last_rdata = e_rd;

    g = 0;
    strobe_seen = 1'b0;
    while (busy && g < 20) begin
      g++;
      strobe_seen = strobe_seen | s_wr | s_rd | s_byte;
      spur = spur_gap && (g == 1);
      @(negedge clk);
    end
    spur = 1'b0;
    chk("gap_len", 32'(g), 32'(T_GAP));
    chk("gap_strobes", 32'(strobe_seen), 32'd0);
  endtask

  initial begin
    int p, r, dly, cnt, arb_port;
    logic [1:0] ty;
    bit early, sg;
    exp_t ex;

    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b1;
    type0 = 2'd1; type1 = 2'd2;
    cmd0 = 8'h11; cmd1 = 8'h22; num0 = 6'd5; num1 = 6'd9;
    wdata0 = $urandom; wdata1 = $urandom;
    spur = 1'b0;
    resp_delay = -1;
    resp_data = 32'd0;
    last_rdata = 32'd0;

    repeat (3) begin
      @(negedge clk);
      chk_zero("reset");
    end

    // First request presented together with reset release
    rst_n = 1'b1;
    req1 = 1'b0;
    do_txn(0, 2'd2, 8'hB0, 6'd7, 32'h0BAD_F00D, 40, 32'h1234_5678, 1'b0, 1'b0);
    do_txn(1, 2'd3, 8'h33, 6'd4, 32'h5555_AAAA, 3, 32'hFFFF_0000, 1'b0, 1'b0);
    do_txn(1, 2'd2, 8'h5A, 6'd31, 32'hA0A0_A0A0, -1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    do_txn(0, 2'd1, 8'hC3, 6'd15, 32'h0123_4567, T_TO, 32'h7777_7777, 1'b0, 1'b1);
    do_txn(0, 2'd2, 8'hC4, 6'd23, 32'h89AB_CDEF, T_TO, 32'h2468_ACE0, 1'b1, 1'b0);
    do_txn(1, 2'd0, 8'h9F, 6'd63, 32'hFFFF_FFFF, 5, 32'h1357_9BDF, 1'b0, 1'b0);

    // Both ports requesting continuously: starvation order
    wait_idle();
    resp_delay = 2;
    resp_data = 32'hCAFE_0001;
    type0 = 2'd2; cmd0 = 8'hA1; num0 = 6'd3; wdata0 = 32'd0;
    type1 = 2'd1; cmd1 = 8'hB2; num1 = 6'd8; wdata1 = 32'h0000_BEEF;
    cnt = 0;
    arb_port = 0;
    for (int k = 0; k < 10; k++) begin
      if (cnt == T_STV) begin
        arb_port = 1; cnt = 0;
      end else begin
        arb_port = 0; cnt++;
      end
      ex.port = arb_port;
      ex.rdata = (arb_port == 0) ? 32'hCAFE_0001 : 32'd0;
      ex.err = 1'b0;
      ex.t = 0;
      sbq.push_back(ex);
    end
    last_rdata = ex.rdata;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int k = 0; k < 400 && sbq.size() != 0; k++) @(negedge clk);
    chk("arb_all_done", 32'(sbq.size()), 32'd0);
    req0 = 1'b0;
    req1 = 1'b0;
    sbq.delete();
    wait_idle();

    // Reset in the middle of BUSY
    resp_delay = -1;
    req0 = 1'b1; type0 = 2'd1; cmd0 = 8'h77; num0 = 6'd3; wdata0 = $urandom;
    @(negedge clk);
    chk("rst_mid_strobe", 32'(s_wr), 32'd1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("rst_mid");
    req0 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("rst_after");
    last_rdata = 32'd0;
    do_txn(0, 2'd2, 8'h42, 6'd12, 32'h0, 6, 32'h600D_CAFE, 1'b0, 1'b0);

    // Randomized single-port traffic
    for (int i = 0; i < 30; i++) begin
      p = int'($urandom_range(0, 1));
      ty = 2'($urandom_range(0, 3));
      r = int'($urandom_range(0, 9));
      if (r < 6) dly = int'($urandom_range(0, 12));
      else if (r == 6) dly = T_TO;
      else if (r == 7) dly = -1;
      else if (r == 8) dly = T_TO - 1;
      else dly = 0;
      early = ($urandom_range(0, 3) == 0);
      sg = ($urandom_range(0, 2) == 0);
      do_txn(p, ty, 8'($urandom), 6'($urandom), $urandom, dly, $urandom, early, sg);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks + mchecks, errors + merrors);
    $finish;
  end

  initial begin
    #(CYC * 60000);
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1);
  end

endmodule
